riscv_nn_instr_profiler: RTL and testbench
==========================================

Name: riscv_nn_instr_profiler

Overview:
Run-time instruction profiler/tracer for the NN-extended core. It matches each retired instruction against NUM_CLASSES software-programmable mask/match pairs. This generalises the tracer's fixed compile-time instruction masks into configurable classes. It keeps saturating per-class counters and buffers trace records in a FIFO for a debug/trace sink. It sits beside the ID/EX retire point and is fed by the core's retire strobe.

Parameters:
NUM_CLASSES, 8, number of programmable mask/match classes (1..32)
CNT_WIDTH, 32, width of each class counter and the drop counter
FIFO_DEPTH, 8, trace-record FIFO depth (power of two, >=2)
CLS_W, $clog2(NUM_CLASSES+1), class-id width; id NUM_CLASSES means "no match"

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  profiling enable; retires are ignored when low
clear_i  in  1  synchronous clear of counters, drop counter and FIFO
retire_valid_i  in  1  one instruction retired this cycle
retire_pc_i  in  32  PC of the retired instruction
retire_instr_i  in  32  uncompressed instruction word
cfg_we_i  in  1  class configuration write strobe
cfg_idx_i  in  CLS_W  class index written (ignored if >= NUM_CLASSES)
cfg_en_i  in  1  class enable bit
cfg_mask_i  in  32  care-bit mask
cfg_match_i  in  32  match value
rd_idx_i  in  CLS_W  counter read select; NUM_CLASSES selects the miss counter
rd_cnt_o  out  CNT_WIDTH  selected counter, combinational from registers
drop_cnt_o  out  CNT_WIDTH  records dropped because the FIFO was full
trace_valid_o  out  1  FIFO head valid
trace_ready_i  in  1  sink accepts head
trace_pc_o  out  32  head PC
trace_instr_o  out  32  head instruction
trace_class_o  out  CLS_W  head first-match class id

Behaviour:
- Reset: all class enables 0, mask/match 0, counters 0, drop_cnt_o 0, FIFO empty, trace_valid_o 0, pipeline stage invalid.
- Stage 1 (cycle N+1): register pc/instr/valid when retire_valid_i && enable_i.
- Stage 1 compare: class k hits when enabled and (instr & mask_k) == (match_k & mask_k). Uses the configuration present in the compare cycle; a cfg write in that same cycle takes effect from the next cycle.
- Stage 2 (visible at N+2): every hitting class counter increments (multi-hit counts all). The miss counter increments if no class hits. All counters saturate at all-ones and never wrap.
- Trace record {pc, instr, first-match id} is pushed at N+2. First match is the lowest hitting index, or NUM_CLASSES if none. An empty FIFO therefore gives trace_valid_o at N+2; there is no fall-through bypass.
- FIFO full at push: if a pop occurs in the same cycle, the push is accepted. Otherwise the record is dropped and drop_cnt_o increments, saturating.
- Pop when trace_valid_o && trace_ready_i. Simultaneous push and pop keeps occupancy unchanged. Pointers are log2(FIFO_DEPTH)+1 bits and wrap.
- clear_i has priority over every same-cycle increment, push and pop. After clear: counters 0, FIFO empty, stage-1 contents discarded. Configuration is kept.
- enable_i deasserted: no new captures. An in-flight stage-1 record still completes.
- Async reset mid-operation clears everything immediately, including configuration.

Decomposition:
- Shared package riscv_nn_tracer_defines gets:
  - trace_rec_t struct {pc, instr, class_id}
  - class_cfg_t struct {en, mask, match}
  - preset constants: e.g. PROF_MASK_RTYPE = 32'hFE00707F; the ADDI class uses mask 32'h0000707F, match 32'h00000013
- Sub-module riscv_nn_trace_fifo: parametrised sync FIFO with width and depth, full/empty, push/pop, flush.

Test Plan:
- Reset, then write class0 = {en=1, mask 0x0000707F, match 0x13}. Retire 0x00500093 (addi) at cycle N -> rd_cnt_o[0]=1 at N+2; trace_class_o=0, trace_pc_o as driven.
- Class1 = {mask 0, match 0, en=1} (matches all) plus class0 as above. Retire addi -> both counters +1, trace_class_o=0. Retire 0x00000033 (add) -> only class1 and trace_class_o=1; miss counter unchanged.
- trace_ready_i=0, 10 back-to-back retires, FIFO_DEPTH=8 -> 8 records held, drop_cnt_o=2, trace_valid_o=1. Then ready=1 -> records drain in order.
- CNT_WIDTH=4, 20 addi retires -> rd_cnt_o[0]=15, not wrapped.
- clear_i asserted in the same cycle as a counted retire and a pop -> counters 0, FIFO empty next cycle, config retained; next addi gives count 1.
- enable_i=0 during 5 retires -> no counter change and no records. rst_i pulsed mid-stream -> all outputs 0 and class enables 0.

Source files
------------

// File: rtl/riscv_nn_tracer_defines.sv
// Shared types and preset mask/match constants for the NN-core instruction tracer/profiler.
package riscv_nn_tracer_defines;

  // Wide enough for a class id of up to 32 classes plus the "no match" id.
  localparam int unsigned CLASS_ID_MAX_W = 6;

  localparam logic [31:0] PROF_MASK_RTYPE  = 32'hFE00707F;
  localparam logic [31:0] PROF_MASK_ITYPE  = 32'h0000707F;
  localparam logic [31:0] PROF_MATCH_ADDI  = 32'h00000013;
  localparam logic [31:0] PROF_MATCH_ADD   = 32'h00000033;

  typedef struct packed {
    logic [31:0]               pc;
    logic [31:0]               instr;
    logic [CLASS_ID_MAX_W-1:0] class_id;
  } trace_rec_t;

  typedef struct packed {
    logic        en;
    logic [31:0] mask;
    logic [31:0] match;
  } class_cfg_t;

  function automatic logic class_hit(class_cfg_t cfg, logic [31:0] instr);
    return cfg.en && ((instr & cfg.mask) == (cfg.match & cfg.mask));
  endfunction

endpackage

// File: rtl/riscv_nn_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush, and push-while-full when a pop frees a slot.
module riscv_nn_trace_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/riscv_nn_instr_profiler.sv
// Retire-point profiler: programmable mask/match classes, saturating per-class counters and a
// trace-record FIFO for a debug sink.
module riscv_nn_instr_profiler
  import riscv_nn_tracer_defines::*;
#(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CLS_W       = $clog2(NUM_CLASSES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 retire_valid_i,
  input  logic [31:0]          retire_pc_i,
  input  logic [31:0]          retire_instr_i,
  input  logic                 cfg_we_i,
  input  logic [CLS_W-1:0]     cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic [31:0]          cfg_mask_i,
  input  logic [31:0]          cfg_match_i,
  input  logic [CLS_W-1:0]     rd_idx_i,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic                 trace_valid_o,
  input  logic                 trace_ready_i,
  output logic [31:0]          trace_pc_o,
  output logic [31:0]          trace_instr_o,
  output logic [CLS_W-1:0]     trace_class_o
);

  localparam int unsigned NUM_CNT = NUM_CLASSES + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  class_cfg_t             cfg_q [NUM_CLASSES];
  logic                   s1_valid_q;
  logic [31:0]            s1_pc_q, s1_instr_q;
  logic [NUM_CLASSES-1:0] hit;
  logic [CLS_W-1:0]       first_id;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_CNT];
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic                   fifo_full, fifo_empty, fifo_pop, drop;
  trace_rec_t             push_rec, head_rec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) cfg_q[k] <= '0;
    end else begin
      // Out-of-range indices match no k and are silently ignored.
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        if (cfg_we_i && cfg_idx_i == CLS_W'(k)) begin
          cfg_q[k] <= '{en: cfg_en_i, mask: cfg_mask_i, match: cfg_match_i};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_instr_q <= '0;
    end else begin
      s1_valid_q <= retire_valid_i && enable_i && !clear_i;
      if (retire_valid_i && enable_i) begin
        s1_pc_q    <= retire_pc_i;
        s1_instr_q <= retire_instr_i;
      end
    end
  end

  always_comb begin
    hit      = '0;
    first_id = CLS_W'(NUM_CLASSES);
    for (int k = 0; k < int'(NUM_CLASSES); k++) hit[k] = class_hit(cfg_q[k], s1_instr_q);
    for (int k = int'(NUM_CLASSES) - 1; k >= 0; k--) begin
      if (hit[k]) first_id = CLS_W'(k);
    end
  end

  assign fifo_pop = trace_valid_o && trace_ready_i;
  assign drop     = s1_valid_q && fifo_full && !fifo_pop;

  always_comb begin
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (clear_i) begin
      for (int k = 0; k < int'(NUM_CNT); k++) cnt_d[k] = '0;
      drop_d = '0;
    end else begin
      if (s1_valid_q) begin
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
          if (hit[k] && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
        end
        if (hit == '0 && cnt_q[NUM_CLASSES] != CNT_MAX) begin
          cnt_d[NUM_CLASSES] = cnt_q[NUM_CLASSES] + 1'b1;
        end
      end
      if (drop && drop_q != CNT_MAX) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NUM_CNT); k++) cnt_q[k] <= '0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int k = 0; k < int'(NUM_CNT); k++) begin
      if (rd_idx_i == CLS_W'(k)) rd_cnt_o = cnt_q[k];
    end
  end

  assign drop_cnt_o = drop_q;
  assign push_rec   = '{pc: s1_pc_q, instr: s1_instr_q, class_id: CLASS_ID_MAX_W'(first_id)};

  riscv_nn_trace_fifo #(
    .WIDTH($bits(trace_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(clear_i),
    .push_i (s1_valid_q),
    .pop_i  (fifo_pop),
    .wdata_i(push_rec),
    .rdata_o(head_rec),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign trace_valid_o = !fifo_empty;
  assign trace_pc_o    = head_rec.pc;
  assign trace_instr_o = head_rec.instr;
  assign trace_class_o = CLS_W'(head_rec.class_id);

endmodule

// File: tb/tb_riscv_nn_instr_profiler.sv
// Scoreboard bench for riscv_nn_instr_profiler: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_riscv_nn_instr_profiler;
  import riscv_nn_tracer_defines::*;

  localparam int NC   = 8;
  localparam int CW   = 4;
  localparam int FD   = 8;
  localparam int CLSW = 4;
  localparam int CMAX = 15;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h00000033;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0, clear = 1'b0, retire_valid = 1'b0;
  logic [31:0] retire_pc = '0, retire_instr = '0;
  logic cfg_we = 1'b0, cfg_en = 1'b0;
  logic [CLSW-1:0] cfg_idx = '0, rd_idx = '0;
  logic [31:0] cfg_mask = '0, cfg_match = '0;
  logic trace_ready = 1'b0;
  logic [CW-1:0] rd_cnt, drop_cnt;
  logic trace_valid;
  logic [31:0] trace_pc, trace_instr;
  logic [CLSW-1:0] trace_class;

  always #5 clk = ~clk;

  riscv_nn_instr_profiler #(
    .NUM_CLASSES(NC),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .clear_i       (clear),
    .retire_valid_i(retire_valid),
    .retire_pc_i   (retire_pc),
    .retire_instr_i(retire_instr),
    .cfg_we_i      (cfg_we),
    .cfg_idx_i     (cfg_idx),
    .cfg_en_i      (cfg_en),
    .cfg_mask_i    (cfg_mask),
    .cfg_match_i   (cfg_match),
    .rd_idx_i      (rd_idx),
    .rd_cnt_o      (rd_cnt),
    .drop_cnt_o    (drop_cnt),
    .trace_valid_o (trace_valid),
    .trace_ready_i (trace_ready),
    .trace_pc_o    (trace_pc),
    .trace_instr_o (trace_instr),
    .trace_class_o (trace_class)
  );

  typedef struct {
    bit [31:0] pc;
    bit [31:0] instr;
    int        cls;
  } rec_t;

  rec_t      exp_q[$];
  bit        m_en[NC];
  bit [31:0] m_mask[NC], m_match[NC];
  int        m_cnt[NC+1];
  int        m_drop, m_occ;
  bit        p_valid;
  bit [31:0] p_pc, p_instr;
  int        checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one retire becomes one record; hits counted, queue models the FIFO.
  always @(posedge clk or posedge rst) begin
    bit popped, any;
    int first;
    if (rst) begin
      for (int k = 0; k < NC; k++) begin
        m_en[k] = 0; m_mask[k] = 0; m_match[k] = 0;
      end
      for (int k = 0; k <= NC; k++) m_cnt[k] = 0;
      m_drop = 0; m_occ = 0; p_valid = 0;
      exp_q.delete();
    end else begin
      if (clear) begin
        for (int k = 0; k <= NC; k++) m_cnt[k] = 0;
        m_drop = 0; m_occ = 0; p_valid = 0;
        exp_q.delete();
      end else begin
        popped = (m_occ > 0) && trace_ready;
        if (p_valid) begin
          any = 0; first = NC;
          for (int k = 0; k < NC; k++) begin
            if (m_en[k] && ((p_instr & m_mask[k]) == (m_match[k] & m_mask[k]))) begin
              if (m_cnt[k] < CMAX) m_cnt[k]++;
              if (!any) first = k;
              any = 1;
            end
          end
          if (!any && m_cnt[NC] < CMAX) m_cnt[NC]++;
          if (m_occ < FD || popped) begin
            exp_q.push_back('{pc: p_pc, instr: p_instr, cls: first});
            m_occ++;
          end else if (m_drop < CMAX) begin
            m_drop++;
          end
        end
        if (popped) m_occ--;
        p_valid = retire_valid && enable;
        p_pc    = retire_pc;
        p_instr = retire_instr;
      end
      if (cfg_we && int'(cfg_idx) < NC) begin
        m_en[cfg_idx] = cfg_en; m_mask[cfg_idx] = cfg_mask; m_match[cfg_idx] = cfg_match;
      end
    end
  end

  // Monitor: compare outputs mid-cycle and pop the scoreboard on each handshake.
  always @(negedge clk) begin
    rec_t r;
    chk("trace_valid", 64'(trace_valid), 64'(m_occ > 0));
    if (trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        chk("trace_unexpected", 64'(trace_pc), 64'hFFFF_FFFF_FFFF);
      end else begin
        r = exp_q.pop_front();
        chk("trace_pc", 64'(trace_pc), 64'(r.pc));
        chk("trace_instr", 64'(trace_instr), 64'(r.instr));
        chk("trace_class", 64'(trace_class), 64'(r.cls));
      end
    end
    if (int'(rd_idx) <= NC) chk("rd_cnt", 64'(rd_cnt), 64'(m_cnt[rd_idx]));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_cfg(int idx, bit en, logic [31:0] m, logic [31:0] v);
    cfg_we = 1; cfg_idx = CLSW'(idx); cfg_en = en; cfg_mask = m; cfg_match = v;
    tick();
    cfg_we = 0;
  endtask

  task automatic retire(logic [31:0] pc, logic [31:0] instr);
    retire_valid = 1; retire_pc = pc; retire_instr = instr;
    tick();
    retire_valid = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 2))
      0:       return {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
      1:       return {7'h00, 10'($urandom), 3'b000, 5'($urandom), 7'h33};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 1;
    tick(); tick();
    rst = 0;
    enable = 1;
    chk("reset_valid", 64'(trace_valid), 64'h0);
    chk("reset_drop", 64'(drop_cnt), 64'h0);

    // Single ADDI class.
    write_cfg(0, 1, PROF_MASK_ITYPE, PROF_MATCH_ADDI);
    rd_idx = 0;
    retire(32'h100, ADDI);
    tick();
    chk("addi_cnt0", 64'(rd_cnt), 64'd1);
    chk("addi_class", 64'(trace_class), 64'd0);
    chk("addi_pc", 64'(trace_pc), 64'h100);
    trace_ready = 1; tick(); trace_ready = 0;

    // Catch-all class1 alongside class0.
    write_cfg(1, 1, 32'h0, 32'h0);
    retire(32'h104, ADDI);
    tick();
    chk("multi_cnt0", 64'(rd_cnt), 64'd2);
    rd_idx = 1; #1;
    chk("multi_cnt1", 64'(rd_cnt), 64'd1);
    retire(32'h108, ADD);
    tick();
    chk("add_cnt1", 64'(rd_cnt), 64'd2);
    rd_idx = CLSW'(NC); #1;
    chk("add_miss", 64'(rd_cnt), 64'd0);
    trace_ready = 1; tick(); tick(); trace_ready = 0;

    // Overfill the FIFO.
    pulse_clear();
    for (int i = 0; i < 10; i++) retire(32'h200 + 32'(4 * i), (i % 2 == 0) ? ADDI : ADD);
    tick(); tick();
    chk("overflow_drop", 64'(drop_cnt), 64'd2);
    chk("overflow_valid", 64'(trace_valid), 64'd1);
    trace_ready = 1;
    repeat (10) tick();
    trace_ready = 0;

    // Counter saturation.
    pulse_clear();
    rd_idx = 0;
    for (int i = 0; i < 20; i++) retire(32'h300 + 32'(4 * i), ADDI);
    tick(); tick();
    chk("sat_cnt0", 64'(rd_cnt), 64'd15);

    // Clear against an in-flight count and a pop.
    pulse_clear();
    retire(32'h400, ADDI);
    tick();
    retire_valid = 1; retire_pc = 32'h404; retire_instr = ADDI;
    tick();
    clear = 1; trace_ready = 1; retire_valid = 0;
    tick();
    clear = 0; trace_ready = 0;
    chk("clear_cnt0", 64'(rd_cnt), 64'd0);
    chk("clear_valid", 64'(trace_valid), 64'd0);
    retire(32'h408, ADDI);
    tick();
    chk("post_clear_cnt0", 64'(rd_cnt), 64'd1);

    // Disabled retires are ignored.
    enable = 0;
    for (int i = 0; i < 5; i++) retire(32'h500 + 32'(4 * i), ADDI);
    tick(); tick();
    chk("disabled_cnt0", 64'(rd_cnt), 64'd1);
    enable = 1;

    // Random traffic, with an asynchronous reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst = 1; #1;
        chk("mid_rst_valid", 64'(trace_valid), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        chk("mid_rst_cnt", 64'(rd_cnt), 64'd0);
        tick();
        rst = 0;
      end
      clear        = ($urandom_range(0, 49) == 0);
      retire_valid = !clear && ($urandom_range(0, 3) != 0);
      retire_pc    = {$urandom} & 32'hFFFF_FFFC;
      retire_instr = rand_instr();
      enable       = ($urandom_range(0, 9) != 0);
      trace_ready  = $urandom_range(0, 1);
      rd_idx       = CLSW'($urandom_range(0, NC));
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_idx      = CLSW'($urandom_range(0, NC + 1));
      cfg_en       = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       cfg_mask = PROF_MASK_ITYPE;
        1:       cfg_mask = PROF_MASK_RTYPE;
        2:       cfg_mask = 32'h0000_007F;
        default: cfg_mask = $urandom;
      endcase
      cfg_match = $urandom_range(0, 1) ? (($urandom_range(0, 1) != 0) ? PROF_MATCH_ADDI
                                                                       : PROF_MATCH_ADD)
                                       : $urandom;
      tick();
    end
    clear = 0; retire_valid = 0; cfg_we = 0; trace_ready = 1;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
